// File: rtl/spi_link.sv
// spi_link: SPI mode-0 slave exchanging 32-bit words with a host, buffered by
// RX/TX word FIFOs that the local side pops/pushes with one-cycle handshakes.
module spi_link #(
  parameter int BUFFER_SIZE  = 8,
  parameter int WORD_SIZE_BY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        intr,
  output logic        communication_rx_empty,
  output logic        communication_tx_empty,
  input  logic        read,
  input  logic        write,
  output logic        read_response,
  output logic        write_response,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        rx_overflow
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int PW = AW + 1;
  localparam int BW = (WORD_SIZE_BY > 1) ? $clog2(WORD_SIZE_BY) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_SIZE_BY - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic          sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_dly_q, sck_dly_d;
  logic          cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d, cs_dly_q, cs_dly_d;
  logic          mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
  logic [1:0]    settle_q, settle_d;
  logic          armed_q, armed_d;
  logic [0:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [30:0]   rx_sr_q, rx_sr_d;
  logic [30:0]   tx_sr_q, tx_sr_d;
  logic          miso_q, miso_d;

  logic [31:0]   rx_mem_q [BUFFER_SIZE];
  logic [31:0]   rx_mem_d [BUFFER_SIZE];
  logic [31:0]   tx_mem_q [BUFFER_SIZE];
  logic [31:0]   tx_mem_d [BUFFER_SIZE];
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;

  logic          rx_overflow_q, rx_overflow_d;
  logic          read_response_q, read_response_d;
  logic          write_response_q, write_response_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          rx_empty_q, rx_empty_d;
  logic          tx_empty_q, tx_empty_d;
  logic          intr_q, intr_d;

  logic          sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;
  logic          rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic          spi_push_s, spi_pop_s;
  logic          rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
  logic [31:0]   rx_word_s, tx_head_s;

  assign sck_rise_s = sck_sync_q & ~sck_dly_q;
  assign sck_fall_s = ~sck_sync_q & sck_dly_q;
  assign cs_fall_s  = ~cs_sync_q & cs_dly_q;
  assign cs_rise_s  = cs_sync_q & ~cs_dly_q;

  assign rx_empty_s = (rx_wr_q == rx_rd_q);
  assign rx_full_s  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_empty_s = (tx_wr_q == tx_rd_q);
  assign tx_full_s  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

  assign rx_word_s  = {rx_sr_q, mosi_sync_q};
  assign tx_head_s  = tx_empty_s ? 32'h0000_0000 : tx_mem_q[tx_rd_q[AW-1:0]];

  assign rx_push_s  = spi_push_s & ~rx_full_s;
  assign rx_pop_s   = read & ~rx_empty_s;
  assign tx_push_s  = write & ~tx_full_s;
  assign tx_pop_s   = spi_pop_s & ~tx_empty_s;

  // Synchronizer chains; arming waits until the chain holds real samples and cs is seen high
  always_comb begin
    sck_meta_d  = sck;
    sck_sync_d  = sck_meta_q;
    sck_dly_d   = sck_sync_q;
    cs_meta_d   = cs;
    cs_sync_d   = cs_meta_q;
    cs_dly_d    = cs_sync_q;
    mosi_meta_d = mosi;
    mosi_sync_d = mosi_meta_q;
    if (settle_q == 2'd3) begin
      settle_d = settle_q;
      armed_d  = armed_q | cs_sync_q;
    end else begin
      settle_d = settle_q + 2'd1;
      armed_d  = armed_q;
    end
  end

  // Transfer control: bit/byte counting, shift registers and miso
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    spi_push_s = 1'b0;
    spi_pop_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s && armed_q) begin
          state_d    = ST_XFER;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = {BW{1'b0}};
          rx_sr_d    = 31'h0;
          spi_pop_s  = 1'b1;
          tx_sr_d    = tx_head_s[30:0];
          miso_d     = tx_head_s[31];
        end else begin
          miso_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = {BW{1'b0}};
          rx_sr_d    = 31'h0;
          tx_sr_d    = 31'h0;
          miso_d     = 1'b0;
        end else if (sck_rise_s) begin
          rx_sr_d   = rx_word_s[30:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + BW'(1'b1);
            if (byte_cnt_q == LAST_BYTE) begin
              spi_push_s = 1'b1;
              spi_pop_s  = 1'b1;
              tx_sr_d    = tx_head_s[30:0];
              miso_d     = tx_head_s[31];
            end else begin
              spi_push_s = 1'b0;
            end
          end else begin
            byte_cnt_d = byte_cnt_q;
          end
        end else if (sck_fall_s) begin
          // The fall right after a word boundary must not shift the freshly loaded word
          if ((bit_cnt_q != 3'd0) || (byte_cnt_q != {BW{1'b0}})) begin
            tx_sr_d = {tx_sr_q[29:0], 1'b0};
            miso_d  = tx_sr_q[30];
          end else begin
            tx_sr_d = tx_sr_q;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  // FIFO storage, pointers and the local-side handshake outputs
  always_comb begin
    rx_mem_d = rx_mem_q;
    tx_mem_d = tx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    if (rx_push_s) begin
      rx_mem_d[rx_wr_q[AW-1:0]] = rx_word_s;
      rx_wr_d = rx_wr_q + PW'(1'b1);
    end else begin
      rx_wr_d = rx_wr_q;
    end
    if (rx_pop_s) begin
      rx_rd_d = rx_rd_q + PW'(1'b1);
    end else begin
      rx_rd_d = rx_rd_q;
    end
    if (tx_push_s) begin
      tx_mem_d[tx_wr_q[AW-1:0]] = write_data;
      tx_wr_d = tx_wr_q + PW'(1'b1);
    end else begin
      tx_wr_d = tx_wr_q;
    end
    if (tx_pop_s) begin
      tx_rd_d = tx_rd_q + PW'(1'b1);
    end else begin
      tx_rd_d = tx_rd_q;
    end
    if (read) begin
      read_data_d = rx_empty_s ? 32'h0000_0000 : rx_mem_q[rx_rd_q[AW-1:0]];
    end else begin
      read_data_d = read_data_q;
    end
    read_response_d  = read;
    write_response_d = write;
    rx_overflow_d    = rx_overflow_q | (spi_push_s & rx_full_s);
    rx_empty_d       = (rx_wr_d == rx_rd_d);
    tx_empty_d       = (tx_wr_d == tx_rd_d);
    intr_d           = ~tx_empty_d;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_meta_q       <= 1'b0;
      sck_sync_q       <= 1'b0;
      sck_dly_q        <= 1'b0;
      cs_meta_q        <= 1'b1;
      cs_sync_q        <= 1'b1;
      cs_dly_q         <= 1'b1;
      mosi_meta_q      <= 1'b0;
      mosi_sync_q      <= 1'b0;
      settle_q         <= 2'd0;
      armed_q          <= 1'b0;
      state_q          <= ST_IDLE;
      bit_cnt_q        <= 3'd0;
      byte_cnt_q       <= {BW{1'b0}};
      rx_sr_q          <= 31'h0;
      tx_sr_q          <= 31'h0;
      miso_q           <= 1'b0;
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        rx_mem_q[i] <= 32'h0000_0000;
        tx_mem_q[i] <= 32'h0000_0000;
      end
      rx_wr_q          <= {PW{1'b0}};
      rx_rd_q          <= {PW{1'b0}};
      tx_wr_q          <= {PW{1'b0}};
      tx_rd_q          <= {PW{1'b0}};
      rx_overflow_q    <= 1'b0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
      read_data_q      <= 32'h0000_0000;
      rx_empty_q       <= 1'b1;
      tx_empty_q       <= 1'b1;
      intr_q           <= 1'b0;
    end else begin
      sck_meta_q       <= sck_meta_d;
      sck_sync_q       <= sck_sync_d;
      sck_dly_q        <= sck_dly_d;
      cs_meta_q        <= cs_meta_d;
      cs_sync_q        <= cs_sync_d;
      cs_dly_q         <= cs_dly_d;
      mosi_meta_q      <= mosi_meta_d;
      mosi_sync_q      <= mosi_sync_d;
      settle_q         <= settle_d;
      armed_q          <= armed_d;
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      byte_cnt_q       <= byte_cnt_d;
      rx_sr_q          <= rx_sr_d;
      tx_sr_q          <= tx_sr_d;
      miso_q           <= miso_d;
      rx_mem_q         <= rx_mem_d;
      tx_mem_q         <= tx_mem_d;
      rx_wr_q          <= rx_wr_d;
      rx_rd_q          <= rx_rd_d;
      tx_wr_q          <= tx_wr_d;
      tx_rd_q          <= tx_rd_d;
      rx_overflow_q    <= rx_overflow_d;
      read_response_q  <= read_response_d;
      write_response_q <= write_response_d;
      read_data_q      <= read_data_d;
      rx_empty_q       <= rx_empty_d;
      tx_empty_q       <= tx_empty_d;
      intr_q           <= intr_d;
    end
  end

  assign miso                   = miso_q;
  assign intr                   = intr_q;
  assign communication_rx_empty = rx_empty_q;
  assign communication_tx_empty = tx_empty_q;
  assign read_response          = read_response_q;
  assign write_response         = write_response_q;
  assign read_data              = read_data_q;
  assign rx_overflow            = rx_overflow_q;

endmodule

// File: tb/tb_spi_link.sv
// tb_spi_link: directed vector table for word exchanges plus hand sequences for
// overflow, aborted words, coincident handshakes and mid-transfer reset.
module tb_spi_link;

  logic        clk = 1'b0;
  logic        reset, sck, cs, mosi, miso, intr;
  logic        rx_empty, tx_empty, read, write, read_response, write_response;
  logic [31:0] write_data, read_data;
  logic        rx_overflow;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        do_wr;
    logic [31:0] wr_word;
    logic [31:0] host_word;
    logic [31:0] exp_rx;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t vecs [4];

  spi_link #(.BUFFER_SIZE(8), .WORD_SIZE_BY(4)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .intr(intr), .communication_rx_empty(rx_empty), .communication_tx_empty(tx_empty),
    .read(read), .write(write), .read_response(read_response),
    .write_response(write_response), .write_data(write_data),
    .read_data(read_data), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    m = miso;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_word(input logic [31:0] w, input int nbits, output logic [31:0] m);
    logic b;
    m = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(w[31-i], b);
      m = {m[30:0], b};
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_read(input string nm, input logic [31:0] exp);
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chkb({nm, "_resp"}, read_response, 1'b1);
    chk({nm, "_data"}, read_data, exp);
    @(negedge clk);
    chkb({nm, "_resp_drop"}, read_response, 1'b0);
    chk({nm, "_data_hold"}, read_data, exp);
  endtask

  task automatic do_write(input logic [31:0] w);
    @(negedge clk);
    write = 1'b1;
    write_data = w;
    @(negedge clk);
    write = 1'b0;
    chkb("write_resp", write_response, 1'b1);
  endtask

  initial begin
    logic [31:0] m;
    logic        b;

    vecs[0] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'hCAFE_F00D, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};

    reset = 1'b0; sck = 1'b0; cs = 1'b1; mosi = 1'b0;
    read = 1'b0; write = 1'b0; write_data = 32'h0;
    repeat (3) @(negedge clk);
    chkb("rst_miso", miso, 1'b0);
    chkb("rst_intr", intr, 1'b0);
    chkb("rst_rx_empty", rx_empty, 1'b1);
    chkb("rst_tx_empty", tx_empty, 1'b1);
    chk("rst_read_data", read_data, 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i].wr_word);
      chkb("vec_intr_pre", intr, vecs[i].do_wr);
      cs_low();
      chkb("vec_intr_loaded", intr, 1'b0);
      spi_word(vecs[i].host_word, 32, m);
      cs_high();
      chk("vec_miso_word", m, vecs[i].exp_miso);
      chkb("vec_miso_idle", miso, 1'b0);
      chkb("vec_rx_nonempty", rx_empty, 1'b0);
      do_read("vec_read", vecs[i].exp_rx);
      chkb("vec_rx_empty", rx_empty, 1'b1);
    end

    // RX overflow: eight words fill the FIFO, the ninth is dropped
    cs_low();
    for (int i = 0; i < 8; i++) spi_word(32'(i + 1) * 32'h0101_0101, 32, m);
    cs_high();
    chkb("ovf_not_yet", rx_overflow, 1'b0);
    cs_low();
    spi_word(32'hBAD0_BAD0, 32, m);
    cs_high();
    chkb("ovf_set", rx_overflow, 1'b1);
    for (int i = 0; i < 8; i++) do_read("ovf_read", 32'(i + 1) * 32'h0101_0101);
    chkb("ovf_drained", rx_empty, 1'b1);
    do_read("empty_read", 32'h0);
    chkb("empty_read_still_empty", rx_empty, 1'b1);

    // Partial word aborted by cs rising, then a clean word
    cs_low();
    spi_word(32'hFFFF_FFFF, 20, m);
    cs_high();
    chkb("abort_miso", miso, 1'b0);
    chkb("abort_rx_empty", rx_empty, 1'b1);
    cs_low();
    spi_word(32'h0000_0001, 32, m);
    cs_high();
    chkb("abort_one_word", rx_empty, 1'b0);
    do_read("abort_read", 32'h0000_0001);
    chkb("abort_rx_empty_after", rx_empty, 1'b1);

    // read and write coincident with an SPI word completion
    do_write(32'h0BAD_F00D);
    do_write(32'h1357_9BDF);
    do_write(32'h2468_ACE0);
    cs_low();
    spi_word(32'hA0A0_A0A0, 32, m);
    chk("coin_miso_x1", m, 32'h0BAD_F00D);
    spi_word(32'hB1B1_B1B1, 31, m);
    chk("coin_miso_x2_head", m, 32'h09AB_CDEF);
    mosi = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    read = 1'b1; write = 1'b1; write_data = 32'h7E57_C0DE;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    chkb("coin_read_resp", read_response, 1'b1);
    chkb("coin_write_resp", write_response, 1'b1);
    chk("coin_read_data", read_data, 32'hA0A0_A0A0);
    @(negedge clk);
    chkb("coin_rx_nonempty", rx_empty, 1'b0);
    chkb("coin_tx_nonempty", tx_empty, 1'b0);
    chkb("coin_intr", intr, 1'b1);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    spi_word(32'hC2C2_C2C2, 32, m);
    chk("coin_miso_x3", m, 32'h2468_ACE0);
    chkb("coin_intr_drained", intr, 1'b0);
    chkb("coin_tx_empty", tx_empty, 1'b1);
    cs_high();
    do_read("coin_read_b", 32'hB1B1_B1B1);
    do_read("coin_read_c", 32'hC2C2_C2C2);
    chkb("coin_rx_empty", rx_empty, 1'b1);

    // Reset two bytes into a transfer
    cs_low();
    spi_word(32'h1122_3344, 32, m);
    do_write(32'h0F0F_0F0F);
    spi_word(32'h5566_7788, 16, m);
    chkb("prerst_intr", intr, 1'b1);
    chkb("prerst_rx_nonempty", rx_empty, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chkb("midrst_miso", miso, 1'b0);
    chkb("midrst_intr", intr, 1'b0);
    chkb("midrst_read_resp", read_response, 1'b0);
    chkb("midrst_write_resp", write_response, 1'b0);
    chk("midrst_read_data", read_data, 32'h0);
    chkb("midrst_rx_empty", rx_empty, 1'b1);
    chkb("midrst_tx_empty", tx_empty, 1'b1);
    chkb("midrst_overflow", rx_overflow, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    spi_word(32'hFFFF_0000, 32, m);
    cs_high();
    chkb("postrst_no_stale_xfer", rx_empty, 1'b1);
    cs_low();
    spi_word(32'hC001_D00D, 32, m);
    cs_high();
    chkb("postrst_rx_nonempty", rx_empty, 1'b0);
    do_read("postrst_read", 32'hC001_D00D);
    chkb("postrst_rx_empty", rx_empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_link.md
SPI_LINK -- requirements
Module: spi_link

Interface
REQ-001 Parameter BUFFER_SIZE, default 8, sets RX and TX FIFO depth in 32-bit words; power of two, min 2.
REQ-002 Parameter WORD_SIZE_BY, default 4, sets bytes per word; only the value 4 is supported.
REQ-003 Port clk, input, 1: system clock; every flop in the block is clocked on its rising edge.
REQ-004 Port reset, input, 1: reset is asynchronous and active-low (0 = reset).
REQ-005 Port sck, input, 1: SPI clock from the host, asynchronous to clk.
REQ-006 Port cs, input, 1: SPI chip select, active-low, asynchronous.
REQ-007 Port mosi, input, 1: SPI data from the host, asynchronous.
REQ-008 Port miso, output, 1: SPI data to the host.
REQ-009 Port intr, output, 1: high while the TX FIFO is non-empty (data pending for the host).
REQ-010 Port communication_rx_empty, output, 1: RX FIFO is empty.
REQ-011 Port communication_tx_empty, output, 1: TX FIFO is empty.
REQ-012 Port read, input, 1: single-cycle pop request on the RX FIFO.
REQ-013 Port write, input, 1: single-cycle push request on the TX FIFO.
REQ-014 Port read_response, output, 1: one-cycle acknowledge of read.
REQ-015 Port write_response, output, 1: one-cycle acknowledge of write.
REQ-016 Port write_data, input, 32: word to transmit.
REQ-017 Port read_data, output, 32: received word; valid while read_response is high.
REQ-018 Port rx_overflow, output, 1: sticky flag, set when a received word is dropped.

Function
REQ-019 sck, cs and mosi shall each pass through a 2-flop synchronizer; edge detection shall use the synchronized value and its one-cycle-delayed copy.
REQ-020 SPI mode 0, MSB first: mosi sampled on a detected sck rising edge; miso updated on a detected sck falling edge.
REQ-021 A cs falling edge shall clear the bit and byte counters, pop the TX head word into the shift register (0x00000000 if the TX FIFO is empty), and drive its bit 31 onto miso before the first sck rise.
REQ-022 The first byte of each word shall map to bits [31:24] and the fourth byte to bits [7:0].
REQ-023 After every 32nd sampled bit, the assembled word shall be pushed into the RX FIFO, and the next TX word shall be popped or zero-filled at the same clk edge.
REQ-024 A word completing while the RX FIFO is full shall be discarded, with rx_overflow set to 1.
REQ-025 A cs rising edge shall discard any partial RX word and any unsent TX bits, clear the counters, and leave miso at 0.
REQ-026 sck edges while cs is high shall be ignored.
REQ-027 read shall pop the RX head and raise read_response exactly 1 cycle later, with read_data holding the popped word.
REQ-028 read on an empty RX FIFO shall raise read_response 1 cycle later with read_data = 0 and leave the FIFO unchanged.
REQ-029 write shall push write_data and raise write_response 1 cycle later; write on a full TX FIFO shall drop the word but still respond.
REQ-030 read and write in the same cycle shall both be serviced.
REQ-031 An SPI-side push and a user pop on the RX FIFO in the same cycle shall both succeed; likewise a user push and an SPI-side pop on the TX FIFO.
REQ-032 The FIFO pointers shall be log2(BUFFER_SIZE)+1 bits wide and wrap modulo 2*BUFFER_SIZE; full = MSBs differ and the low bits are equal.
REQ-033 read_data shall hold its last value when read_response is low.

Reset
REQ-034 While reset = 0, the following shall be cleared: both FIFOs, counters, shift registers, synchronizers (cs synchronizer preset to 1), and rx_overflow.
REQ-035 Output values during reset: miso = 0, intr = 0, read_response = 0, write_response = 0, read_data = 0, communication_rx_empty = 1, communication_tx_empty = 1.
REQ-036 Reset asserted mid-transfer shall abort it with no FIFO push; after release, only a fresh cs falling edge shall start a new transfer.

Verification
REQ-037 Host sends bytes DE AD BE EF under a single cs low, then read is pulsed -> read_response 1 cycle later with read_data = 32'hDEADBEEF and communication_rx_empty = 1.
REQ-038 write 32'h12345678 is issued, then the host clocks 32 bits -> intr = 1 before the transfer; miso bit stream equals 0x12345678 MSB first; intr = 0 after the pop.
REQ-039 BUFFER_SIZE+1 words are received with no reads -> first BUFFER_SIZE words read back in order, rx_overflow = 1, no corruption.
REQ-040 cs is deasserted after 20 bits, then a full word 0x00000001 is sent -> exactly one word 0x00000001 is in the RX FIFO.
REQ-041 read and write are pulsed in the same cycle while an SPI word completes -> both responses appear 1 cycle later and FIFO counts are correct.
REQ-042 reset = 0 is asserted after 2 bytes of a transfer -> all outputs take their reset values, and the next transfer is received correctly.
